// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator stack controller.
//   - state_t   : sequencer states
//   - ERR_*     : err_code encodings
//   - *_DEF     : default widths / depth used by the controller parameters
package rpn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PUSH_WR = 4'd1,
    ST_RD_B    = 4'd2,
    ST_CAP_B   = 4'd3,
    ST_RD_A    = 4'd4,
    ST_CAP_A   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_WB      = 4'd7,
    ST_ERROR   = 4'd8
  } state_t;

endpackage

// File: rtl/rpn_stack_ctrl.sv
// Stack sequencer for the RPN calculator datapath.
// Owns the stack pointer, drives the single-port stack RAM (registered
// address/data/write-enable), the ALU operand and op-select registers and
// write-back of the ALU result. Executes PUSH and OPERATE (pop B, pop A,
// push A op B) and flags stack underflow / overflow in a sticky ERROR state.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_req/push_data  single-cycle push request and its value
//   op_req/op_sel       single-cycle operate request and ALU operation
//   err_clr             leave ERROR state
//   mem_addr/mem_wdata/mem_wren  stack RAM interface (registered)
//   mem_rdata           RAM q, valid one edge after the address is sampled
//   alu_a/alu_b/alu_op  ALU operand and operation registers
//   alu_result          combinational ALU output
//   busy/done/err/err_code/depth  status
//
// DEPTH must not exceed 2**ADDR_W.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_req,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       op_req,
  input  logic [2:0]                 op_sel,
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_wren,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [2:0]                 alu_op,
  input  logic [DATA_W-1:0]          alu_result,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int SP_W = $clog2(DEPTH+1);

  state_t            state_r;
  state_t            state_s;
  logic [SP_W-1:0]   sp_r;
  logic [SP_W-1:0]   sp_s;
  logic [SP_W-1:0]   sp_m1_s;
  logic [SP_W-1:0]   sp_m2_s;
  logic              full_s;
  logic              under_s;

  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              mem_wren_s;
  logic [DATA_W-1:0] alu_a_s;
  logic [DATA_W-1:0] alu_b_s;
  logic [2:0]        alu_op_s;
  logic              busy_s;
  logic              done_s;
  logic              err_s;
  logic [1:0]        err_code_s;

  assign depth   = sp_r;
  assign sp_m1_s = sp_r - SP_W'(1);
  assign sp_m2_s = sp_r - SP_W'(2);
  assign full_s  = (sp_r == SP_W'(DEPTH));
  // Extended by one bit so the "< 2" test stays correct even for a 1-bit sp.
  assign under_s = ({1'b0, sp_r} < (SP_W+1)'(2));

  // Next-state and next-output decode for the command sequencer.
  always_comb begin
    state_s     = state_r;
    sp_s        = sp_r;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    mem_wren_s  = 1'b0;
    alu_a_s     = alu_a;
    alu_b_s     = alu_b;
    alu_op_s    = alu_op;
    done_s      = 1'b0;
    err_code_s  = err_code;

    case (state_r)
      ST_IDLE: begin
        // op_req has priority; a simultaneous push is dropped.
        if (op_req) begin
          if (under_s) begin
            state_s    = ST_ERROR;
            err_code_s = ERR_UNDER;
          end else begin
            alu_op_s   = op_sel;
            mem_addr_s = ADDR_W'(sp_m1_s);
            state_s    = ST_RD_B;
          end
        end else if (push_req) begin
          if (full_s) begin
            state_s    = ST_ERROR;
            err_code_s = ERR_OVER;
          end else begin
            mem_addr_s  = ADDR_W'(sp_r);
            mem_wdata_s = push_data;
            mem_wren_s  = 1'b1;
            sp_s        = sp_r + SP_W'(1);
            state_s     = ST_PUSH_WR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_PUSH_WR: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end

      // RAM samples the address on this edge; q is usable one edge later.
      ST_RD_B: begin
        state_s = ST_CAP_B;
      end

      ST_CAP_B: begin
        alu_b_s    = mem_rdata;
        mem_addr_s = ADDR_W'(sp_m2_s);
        state_s    = ST_RD_A;
      end

      ST_RD_A: begin
        state_s = ST_CAP_A;
      end

      ST_CAP_A: begin
        alu_a_s = mem_rdata;
        state_s = ST_EXEC;
      end

      // Result overwrites entry A; sp drops by one (two popped, one pushed).
      ST_EXEC: begin
        mem_addr_s  = ADDR_W'(sp_m2_s);
        mem_wdata_s = alu_result;
        mem_wren_s  = 1'b1;
        sp_s        = sp_m1_s;
        state_s     = ST_WB;
      end

      ST_WB: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end

      ST_ERROR: begin
        if (err_clr) begin
          err_code_s = ERR_NONE;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_ERROR;
        end
      end

      default: begin
        err_code_s = ERR_NONE;
        state_s    = ST_IDLE;
      end
    endcase

    // Status flags are registered alongside the state they describe.
    busy_s = (state_s != ST_IDLE);
    err_s  = (state_s == ST_ERROR);
  end

  // State, stack pointer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      sp_r      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state_r   <= state_s;
      sp_r      <= sp_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      mem_wren  <= mem_wren_s;
      alu_a     <= alu_a_s;
      alu_b     <= alu_b_s;
      alu_op    <= alu_op_s;
      busy      <= busy_s;
      done      <= done_s;
      err       <= err_s;
      err_code  <= err_code_s;
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Testbench for rpn_stack_ctrl: RAM and ALU models plus a queue-based
// stack reference model driven by directed and randomized commands.
module tb_rpn_stack_ctrl;
  import rpn_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int DP  = 4;
  localparam int SPW = $clog2(DP+1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           push_req = 1'b0;
  logic [DW-1:0]  push_data = 8'h00;
  logic           op_req = 1'b0;
  logic [2:0]     op_sel = 3'd0;
  logic           err_clr = 1'b0;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_wren;
  logic [DW-1:0]  mem_rdata;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [2:0]     alu_op;
  logic [DW-1:0]  alu_result;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     err_code;
  logic [SPW-1:0] depth;

  int n_cmp = 0;
  int n_err = 0;

  // environment models
  logic [DW-1:0] ram [256];
  int            wr_cnt = 0;
  int            done_cnt = 0;
  logic [AW-1:0] last_waddr = 8'h00;
  logic [DW-1:0] last_wdata = 8'h00;

  // reference stack model
  logic [DW-1:0] stk [$];
  bit            m_err = 1'b0;
  logic [1:0]    m_code = 2'b00;

  rpn_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_req(push_req), .push_data(push_data),
    .op_req(op_req), .op_sel(op_sel), .err_clr(err_clr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .depth(depth)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  // single-port RAM with registered address, plus write/done monitors
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_waddr    <= mem_addr;
      last_wdata    <= mem_wdata;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    stk.delete();
    m_err  = 1'b0;
    m_code = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wren, alu_a, alu_b, alu_op, busy, done, err, err_code, depth} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr=%0h wd=%0h wren=%0b a=%0h b=%0h op=%0d busy=%0b done=%0b err=%0b code=%0d depth=%0d, want all 0",
               mem_addr, mem_wdata, mem_wren, alu_a, alu_b, alu_op, busy, done, err, err_code, depth);
    end
    do_reset();
  endtask

  // Issue one command and check it against the reference model.
  task automatic run_cmd(input bit is_op, input bit also_push, input logic [2:0] op,
                         input logic [DW-1:0] d, input bit poke, input string tag);
    int            lat_exp = 0;
    int            wr_exp = 0;
    int            cyc = 0;
    int            wr0;
    int            dn0;
    bit            busy_ok = 1'b1;
    bit            err_exp = 1'b0;
    bit            ram_ok = 1'b1;
    logic [1:0]    code_exp = 2'b00;
    logic [AW-1:0] addr_exp = 8'h00;
    logic [DW-1:0] data_exp = 8'h00;
    logic [DW-1:0] a = 8'h00;
    logic [DW-1:0] b = 8'h00;

    wr0 = wr_cnt;
    dn0 = done_cnt;

    if (m_err) begin
      // requests in ERROR are dropped
      push_req = !is_op || also_push;
      op_req   = is_op;
      op_sel   = op;
      push_data = d;
      tick();
      push_req = 1'b0;
      op_req   = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      n_cmp++;
      if (done_cnt != dn0 || wr_cnt != wr0 || err !== 1'b1 || err_code !== m_code ||
          int'(depth) != stk.size()) begin
        n_err++;
        $display("FAIL %s_dropped_in_error: got done=%0d wr=%0d err=%0b code=%0d depth=%0d, want done=0 wr=0 err=1 code=%0d depth=%0d",
                 tag, done_cnt - dn0, wr_cnt - wr0, err, err_code, depth, m_code, stk.size());
      end
      return;
    end

    if (is_op) begin
      if (stk.size() < 2) begin
        err_exp  = 1'b1;
        code_exp = ERR_UNDER;
      end else begin
        b = stk.pop_back();
        a = stk.pop_back();
        addr_exp = AW'(stk.size());
        data_exp = alu_f(a, b, op);
        stk.push_back(data_exp);
        wr_exp  = 1;
        lat_exp = 6;
      end
    end else begin
      if (stk.size() == DP) begin
        err_exp  = 1'b1;
        code_exp = ERR_OVER;
      end else begin
        addr_exp = AW'(stk.size());
        data_exp = d;
        stk.push_back(d);
        wr_exp  = 1;
        lat_exp = 1;
      end
    end

    push_req  = !is_op || also_push;
    op_req    = is_op;
    op_sel    = op;
    push_data = d;
    tick();
    push_req  = 1'b0;
    op_req    = 1'b0;
    op_sel    = 3'($urandom);
    push_data = 8'($urandom);

    while (!done && !err && cyc < 10) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke && cyc == 2) push_req = 1'b1;
      tick();
      push_req = 1'b0;
      cyc++;
    end

    n_cmp++;
    if (!busy_ok) begin
      n_err++;
      $display("FAIL %s_busy: got busy low during command, want busy high", tag);
    end

    if (err_exp) begin
      tick();
      tick();
      m_err  = 1'b1;
      m_code = code_exp;
      n_cmp++;
      if (err !== 1'b1 || err_code !== code_exp || cyc != 0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s_error_entry: got err=%0b code=%0d cyc=%0d busy=%0b, want err=1 code=%0d cyc=0 busy=1",
                 tag, err, err_code, cyc, busy, code_exp);
      end
    end else begin
      n_cmp++;
      if (done !== 1'b1 || cyc != lat_exp) begin
        n_err++;
        $display("FAIL %s_done_latency: got done=%0b after %0d cycles, want done=1 after %0d",
                 tag, done, cyc, lat_exp);
      end
    end

    n_cmp++;
    if ((wr_cnt - wr0) != wr_exp || (wr_exp == 1 && (last_waddr !== addr_exp || last_wdata !== data_exp))) begin
      n_err++;
      $display("FAIL %s_write: got %0d writes last addr=%0h data=%0h, want %0d writes addr=%0h data=%0h",
               tag, wr_cnt - wr0, last_waddr, last_wdata, wr_exp, addr_exp, data_exp);
    end

    n_cmp++;
    if (int'(depth) != stk.size()) begin
      n_err++;
      $display("FAIL %s_depth: got %0d, want %0d", tag, depth, stk.size());
    end

    if (is_op && !err_exp) begin
      n_cmp++;
      if (alu_a !== a || alu_b !== b || alu_op !== op) begin
        n_err++;
        $display("FAIL %s_operands: got a=%0h b=%0h op=%0d, want a=%0h b=%0h op=%0d",
                 tag, alu_a, alu_b, alu_op, a, b, op);
      end
    end

    for (int i = 0; i < stk.size(); i++) begin
      if (ram[i] !== stk[i]) ram_ok = 1'b0;
    end
    n_cmp++;
    if (!ram_ok) begin
      n_err++;
      $display("FAIL %s_ram_contents: got ram[0..3]=%0h %0h %0h %0h, want stack of %0d entries from model",
               tag, ram[0], ram[1], ram[2], ram[3], stk.size());
    end

    if (!err_exp) begin
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || (wr_cnt - wr0) != wr_exp) begin
        n_err++;
        $display("FAIL %s_done_pulse: got done=%0b busy=%0b writes=%0d, want done=0 busy=0 writes=%0d",
                 tag, done, busy, wr_cnt - wr0, wr_exp);
      end
    end
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err   = 1'b0;
    m_code  = 2'b00;
    n_cmp++;
    if (err !== 1'b0 || err_code !== ERR_NONE || busy !== 1'b0 || int'(depth) != stk.size()) begin
      n_err++;
      $display("FAIL %s_err_clr: got err=%0b code=%0d busy=%0b depth=%0d, want err=0 code=0 busy=0 depth=%0d",
               tag, err, err_code, busy, depth, stk.size());
    end
  endtask

  task automatic test_push_operate();
    run_cmd(1'b0, 1'b0, 3'd0, 8'd5, 1'b0, "push5");
    run_cmd(1'b0, 1'b0, 3'd0, 8'd7, 1'b0, "push7");
    run_cmd(1'b0, 1'b0, 3'd0, 8'd2, 1'b0, "push2");
    run_cmd(1'b1, 1'b0, 3'd1, 8'd0, 1'b0, "sub");
  endtask

  task automatic test_underflow();
    do_reset();
    run_cmd(1'b0, 1'b0, 3'd0, 8'd9, 1'b0, "push9");
    run_cmd(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, "underflow");
    run_cmd(1'b0, 1'b0, 3'd0, 8'd1, 1'b0, "push_in_err");
    clear_err("underflow");
    run_cmd(1'b0, 1'b0, 3'd0, 8'h33, 1'b0, "push_after_clr");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DP; i++) run_cmd(1'b0, 1'b0, 3'd0, 8'(8'h10 + i), 1'b0, "fill");
    run_cmd(1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, "overflow");
    clear_err("overflow");
  endtask

  task automatic test_simultaneous();
    do_reset();
    run_cmd(1'b0, 1'b0, 3'd0, 8'd3, 1'b0, "push3");
    run_cmd(1'b0, 1'b0, 3'd0, 8'd4, 1'b0, "push4");
    run_cmd(1'b1, 1'b1, 3'd0, 8'hEE, 1'b1, "op_wins");
  endtask

  task automatic test_reset_mid_exec();
    int wr0;
    do_reset();
    run_cmd(1'b0, 1'b0, 3'd0, 8'd20, 1'b0, "pre_a");
    run_cmd(1'b0, 1'b0, 3'd0, 8'd30, 1'b0, "pre_b");
    wr0 = wr_cnt;
    op_req = 1'b1;
    op_sel = 3'd0;
    tick();
    op_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wren, alu_a, alu_b, alu_op, busy, done, err, err_code, depth} !== '0) begin
      n_err++;
      $display("FAIL exec_reset_outputs: got addr=%0h wd=%0h wren=%0b a=%0h b=%0h busy=%0b depth=%0d, want all 0",
               mem_addr, mem_wdata, mem_wren, alu_a, alu_b, busy, depth);
    end
    tick();
    n_cmp++;
    if (wr_cnt != wr0) begin
      n_err++;
      $display("FAIL exec_reset_no_write: got %0d writes, want 0", wr_cnt - wr0);
    end
    rst_n = 1'b1;
    stk.delete();
    m_err = 1'b0;
    run_cmd(1'b0, 1'b0, 3'd0, 8'h5A, 1'b0, "push_after_rst");
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 200; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3)      run_cmd(1'b0, 1'b0, 3'($urandom), 8'($urandom), 1'b0, "rnd_push");
      else if (r <= 6) run_cmd(1'b1, 1'b0, 3'($urandom), 8'($urandom), r == 6, "rnd_op");
      else if (r == 7) run_cmd(1'b1, 1'b1, 3'($urandom), 8'($urandom), 1'b0, "rnd_both");
      else             clear_err("rnd");
    end
  endtask

  initial begin
    test_reset();
    test_push_operate();
    test_underflow();
    test_overflow();
    test_simultaneous();
    test_reset_mid_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
